// File: rtl/d3s_upsample_divide_n.sv
// N-sub-phase phase upsampler with Frev-aligned RF phase divider (divider/Frev FSM under D3S_UPSAMPLE_DIV_EN).
// Latency: phase_i->phase_up_o 2 cycles, phase_i->phase_div_o 3 cycles; no backpressure, one sample per clock.
module d3s_upsample_divide_n #(
  parameter int G_PHASE_BITS    = 14,
  parameter int G_SUBPHASES     = 4,
  parameter int G_ACC_FRAC_BITS = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     phase_valid_i,
  input  logic [G_PHASE_BITS-1:0]                  phase_i,
  input  logic [G_PHASE_BITS+G_ACC_FRAC_BITS-1:0]  dt_alias_i,
  input  logic                                     tm_time_valid_i,
  input  logic [31:0]                              tm_tai_i,
  input  logic [27:0]                              tm_cycles_i,
  input  logic                                     frev_ts_valid_i,
  input  logic [31:0]                              frev_ts_tai_i,
  input  logic [31:0]                              frev_ts_nsec_i,
  input  logic [31:0]                              frev_adjust_ns_i,
  input  logic [1:0]                               div_log2_i,
  input  logic [G_PHASE_BITS-1:0]                  div_bias_i,
  output logic [G_SUBPHASES*G_PHASE_BITS-1:0]      phase_up_o,
  output logic [G_SUBPHASES*G_PHASE_BITS-1:0]      phase_div_o,
  output logic                                     div_locked_o,
  output logic [G_PHASE_BITS-1:0]                  div_start_phase_o
);

  localparam int P    = G_PHASE_BITS;
  localparam int N    = G_SUBPHASES;
  localparam int F    = G_ACC_FRAC_BITS;
  localparam int A    = P + F;
  localparam int LG_N = $clog2(N);

  // (d*k)/N for constant k < 8, built from shifted copies of d
  function automatic logic [P-1:0] frac_p(input logic [P-1:0] d, input int k);
    logic [P+2:0] prod;
    prod = '0;
    for (int b = 0; b < 3; b++) begin
      if (k[b]) prod = prod + ({3'b000, d} << b);
    end
    return P'(prod >> LG_N);
  endfunction

  function automatic logic [A-1:0] frac_a(input logic [A-1:0] d, input int k);
    logic [A+2:0] prod;
    prod = '0;
    for (int b = 0; b < 3; b++) begin
      if (k[b]) prod = prod + ({3'b000, d} << b);
    end
    return A'(prod >> LG_N);
  endfunction

  logic [P-1:0] phase_d_q;
  logic [P-1:0] diff;
  logic [A-1:0] acc_q;
  logic [A-1:0] acc_d;
  logic [A-1:0] dt_q;
  logic [A-1:0] acc_k    [N];
  logic [P-1:0] interp_d [N];
  logic [P-1:0] interp_q [N];
  logic [P-1:0] up_d     [N];
  logic [P-1:0] up_q     [N];

  always_comb begin
    diff  = phase_valid_i ? (phase_i - phase_d_q) : '0;
    acc_d = (tm_cycles_i == '0) ? dt_alias_i : (acc_q + dt_alias_i);
    for (int k = 0; k < N; k++) begin
      interp_d[k] = phase_d_q + frac_p(diff, k);
      acc_k[k]    = acc_q + frac_a(dt_q, k);
      up_d[k]     = acc_k[k][A-1:F] - interp_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_d_q <= '0;
      acc_q     <= '0;
      dt_q      <= '0;
      for (int k = 0; k < N; k++) begin
        interp_q[k] <= '0;
        up_q[k]     <= '0;
      end
    end else begin
      if (phase_valid_i) phase_d_q <= phase_i;
      acc_q <= acc_d;
      dt_q  <= dt_alias_i;
      for (int k = 0; k < N; k++) begin
        interp_q[k] <= interp_d[k];
        up_q[k]     <= up_d[k];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_up_pack
    assign phase_up_o[g*P +: P] = up_q[g];
  end

`ifdef D3S_UPSAMPLE_DIV_EN

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MATCH, S_PENDING} frev_state_t;

  localparam logic [31:0] NS_PER_S = 32'd1_000_000_000;

  frev_state_t       state_q, state_d;
  logic [31:0]       tai_q, ns_adj_q;
  logic [31:0]       ns_sum, ns_norm, tai_norm;
  logic [P-1:0]      up_last_q;
  logic [N-1:0]      zc, zc_masked, align_vec;
  logic [2:0]        s_val;
  logic              ts_latch, align;
  logic [LG_N-1:0]   align_k;
  logic              locked_q;
  logic [P-1:0]      start_q;
  logic [2:0]        cnt_q, cnt_d, rmax, c;
  logic              run;
  logic [P-1:0]      div_d [N];
  logic [P-1:0]      div_q [N];

  always_comb begin
    ns_sum   = frev_ts_nsec_i + frev_adjust_ns_i;
    ns_norm  = ns_sum;
    tai_norm = frev_ts_tai_i;
    if (ns_sum >= NS_PER_S) begin
      ns_norm  = ns_sum - NS_PER_S;
      tai_norm = frev_ts_tai_i + 32'd1;
    end
  end

  // Wrap detection across sub-phases; sub-phase 0 compares with the previous cycle's last one
  always_comb begin
    zc[0] = up_last_q > up_q[0];
    for (int k = 1; k < N; k++) zc[k] = up_q[k-1] > up_q[k];
    s_val = 3'(({3'b000, ns_adj_q[2:0]} << LG_N) >> 3);
    for (int k = 0; k < N; k++) zc_masked[k] = zc[k] && (k >= int'(s_val));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (tm_time_valid_i && frev_ts_valid_i) state_d = S_ARMED;
      S_ARMED:   if ((tai_q == tm_tai_i) && (ns_adj_q[31:3] == {1'b0, tm_cycles_i})) state_d = S_MATCH;
      S_MATCH:   state_d = (|zc_masked) ? S_IDLE : S_PENDING;
      S_PENDING: if (|zc) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ts_latch  = 1'b0;
    align_vec = '0;
    case (state_q)
      S_IDLE:    ts_latch  = tm_time_valid_i && frev_ts_valid_i;
      S_MATCH:   align_vec = zc_masked;
      S_PENDING: align_vec = zc;
      default:   ;
    endcase
  end

  always_comb begin
    align   = |align_vec;
    align_k = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (align_vec[k]) align_k = LG_N'(k);
    end
  end

  // Turn counter ripples through the sub-phases; it stays at 0 until the first alignment
  always_comb begin
    rmax = 3'((4'd1 << div_log2_i) - 4'd1);
    c    = cnt_q;
    run  = locked_q;
    for (int k = 0; k < N; k++) begin
      if (align && (LG_N'(k) == align_k)) begin
        c   = '0;
        run = 1'b1;
      end else if (zc[k] && run) begin
        c = (c >= rmax) ? 3'd0 : (c + 3'd1);
      end
      div_d[k] = P'({c, up_q[k]} >> div_log2_i) + div_bias_i;
    end
    cnt_d = c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tai_q     <= '0;
      ns_adj_q  <= '0;
      locked_q  <= 1'b0;
      start_q   <= '0;
      cnt_q     <= '0;
      up_last_q <= '0;
      for (int k = 0; k < N; k++) div_q[k] <= '0;
    end else begin
      if (ts_latch) begin
        tai_q    <= tai_norm;
        ns_adj_q <= ns_norm;
      end
      if (align) begin
        locked_q <= 1'b1;
        start_q  <= up_q[align_k];
      end
      cnt_q     <= cnt_d;
      up_last_q <= up_q[N-1];
      for (int k = 0; k < N; k++) div_q[k] <= div_d[k];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_div_pack
    assign phase_div_o[g*P +: P] = div_q[g];
  end
  assign div_locked_o      = locked_q;
  assign div_start_phase_o = start_q;

`else

  assign phase_div_o       = '0;
  assign div_locked_o      = 1'b0;
  assign div_start_phase_o = '0;

  logic unused_ok;
  assign unused_ok = ^{tm_time_valid_i, tm_tai_i, frev_ts_valid_i, frev_ts_tai_i,
                       frev_ts_nsec_i, frev_adjust_ns_i, div_log2_i, div_bias_i};

`endif

endmodule
